// File: rtl/ncpu32k_cell_pipebuf_if.sv
// ncpu32k_cell_pipebuf_if
// Handshake bundle for the two-entry pipeline buffer.
//   slave  : the buffer's view (takes din/in_valid/out_ready, drives the rest)
//   master : the surrounding logic's view (producer + consumer sides)
// Optional flush line exists only when NCPU_PIPEBUF_FLUSH_EN is defined.
interface ncpu32k_cell_pipebuf_if #(
  parameter int DW = 1
);
  // upstream side
  logic [DW-1:0] din;
  logic          in_valid;
  logic          in_ready;
  // downstream side
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  // occupancy
  logic [1:0]    count;
`ifdef NCPU_PIPEBUF_FLUSH_EN
  logic          flush;
`endif

`ifdef NCPU_PIPEBUF_FLUSH_EN
  modport slave (
    input  din,
    input  in_valid,
    output in_ready,
    output dout,
    output out_valid,
    input  out_ready,
    input  flush,
    output count
  );

  modport master (
    output din,
    output in_valid,
    input  in_ready,
    input  dout,
    input  out_valid,
    output out_ready,
    output flush,
    input  count
  );
`else
  modport slave (
    input  din,
    input  in_valid,
    output in_ready,
    output dout,
    output out_valid,
    input  out_ready,
    output count
  );

  modport master (
    output din,
    output in_valid,
    input  in_ready,
    input  dout,
    input  out_valid,
    output out_ready,
    input  count
  );
`endif

endinterface

// File: rtl/ncpu32k_cell_pipebuf.sv
// ncpu32k_cell_pipebuf
// Two-entry valid/ready skid buffer. The main register feeds dout; the skid
// register catches the one extra word accepted while the consumer stalls.
// in_ready is derived only from local state and RST_n, so no combinational
// path runs from out_ready back to the producer.
// Optional feature: define NCPU_PIPEBUF_FLUSH_EN to add a flush input that
// empties the buffer (data registers keep their contents).
module ncpu32k_cell_pipebuf #(
  parameter int             DW         = 1,
  parameter logic [DW-1:0]  RST_VECTOR = {DW{1'b0}}
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  ncpu32k_cell_pipebuf_if.slave         bus
);

  // Occupancy encoding; the value 2'b11 is unused and recovers to EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          out_valid_q, out_valid_d;
  logic          not_full_q, not_full_d;
  logic [1:0]    count_q, count_d;

  logic          in_ready;
  logic          push;
  logic          pop;
  logic          flush;

`ifdef NCPU_PIPEBUF_FLUSH_EN
  assign flush = bus.flush;
`else
  assign flush = 1'b0;
`endif

  // Handshake qualifiers; in_ready never looks at out_ready or in_valid.
  assign in_ready = RST_n & not_full_q;
  assign push     = bus.in_valid & in_ready;
  assign pop      = out_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.dout      = main_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;

  // Next-state and datapath selection for the two storage registers.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = bus.din;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          // Head leaves while the new word takes its place.
          main_d = bus.din;
        end else if (push) begin
          // Consumer stalled: park the new word behind the head.
          state_d = ST_FULL;
          skid_d  = bus.din;
        end else if (pop) begin
          // main keeps the consumed word so dout stays defined.
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush wins over any concurrent transfer; stored data is left alone.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Registered status outputs, all derived from the next state.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    not_full_d  = (state_d != ST_FULL);
    count_d     = 2'd0;
    case (state_d)
      ST_ONE:  count_d = 2'd1;
      ST_FULL: count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= RST_VECTOR;
      skid_q      <= RST_VECTOR;
      out_valid_q <= 1'b0;
      not_full_q  <= 1'b1;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      not_full_q  <= not_full_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_ncpu32k_cell_pipebuf.sv
// tb_ncpu32k_cell_pipebuf
// Directed scenarios followed by random traffic, checked against a queue-based
// FIFO model of the buffer (DW=8, RST_VECTOR=8'hA5).
// Build with +define+NCPU_PIPEBUF_FLUSH_EN to exercise the flush input.
module tb_ncpu32k_cell_pipebuf;

  localparam int             DW   = 8;
  localparam logic [DW-1:0]  RSTV = 8'hA5;

  logic CLK;
  logic RST_n;

  int vectors;
  int miscompares;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;

  ncpu32k_cell_pipebuf_if #(.DW(DW)) pb_if ();

  ncpu32k_cell_pipebuf #(
    .DW         (DW),
    .RST_VECTOR (RSTV)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (pb_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_dout();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  // One clock cycle: drive, check in_ready before the edge, update the model
  // with the rules of a 2-deep FIFO, then check registered outputs after it.
  task automatic cycle(input bit rst_n_i, input bit iv, input logic [DW-1:0] d,
                       input bit ordy, input bit fl);
    bit m_in_ready, m_push, m_pop;
    RST_n             = rst_n_i;
    pb_if.in_valid    = iv;
    pb_if.din         = d;
    pb_if.out_ready   = ordy;
`ifdef NCPU_PIPEBUF_FLUSH_EN
    pb_if.flush       = fl;
`endif
    #1;
    m_in_ready = rst_n_i && (mq.size() < 2);
    check("in_ready", {31'd0, pb_if.in_ready}, {31'd0, m_in_ready});
    m_push = iv && m_in_ready;
    m_pop  = (mq.size() > 0) && ordy;
    if (!rst_n_i) begin
      mq.delete();
      m_last = RSTV;
    end else if (fl) begin
      if (mq.size() > 0) m_last = mq[0];
      mq.delete();
    end else begin
      if (mq.size() > 0) m_last = mq[0];
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(d);
    end
    @(posedge CLK);
    #1;
    check("out_valid", {31'd0, pb_if.out_valid}, {31'd0, mq.size() > 0});
    check("count", {30'd0, pb_if.count}, mq.size());
    check("dout", {24'd0, pb_if.dout}, {24'd0, model_dout()});
    $display("cyc rst_n=%0b iv=%0b din=%02h ordy=%0b fl=%0b -> ov=%0b dout=%02h cnt=%0d",
             rst_n_i, iv, d, ordy, fl, pb_if.out_valid, pb_if.dout, pb_if.count);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_last      = RSTV;
    RST_n            = 1'b0;
    pb_if.in_valid   = 1'b0;
    pb_if.din        = '0;
    pb_if.out_ready  = 1'b0;
`ifdef NCPU_PIPEBUF_FLUSH_EN
    pb_if.flush      = 1'b0;
`endif
    @(posedge CLK);
    #1;

    // reset for two cycles, with traffic offered that must be ignored
    cycle(0, 1, 8'hEE, 1, 0);
    cycle(0, 1, 8'hEF, 1, 0);
    check("rst_dout_const", {24'd0, pb_if.dout}, 32'hA5);
    check("rst_count_const", {30'd0, pb_if.count}, 32'd0);

    // streaming at full rate
    cycle(1, 1, 8'h01, 1, 0);
    check("stream_01", {24'd0, pb_if.dout}, 32'h01);
    cycle(1, 1, 8'h02, 1, 0);
    check("stream_02", {24'd0, pb_if.dout}, 32'h02);
    cycle(1, 1, 8'h03, 1, 0);
    check("stream_03", {24'd0, pb_if.dout}, 32'h03);
    cycle(1, 0, 8'h00, 1, 0);

    // backpressure: fill, refused third offer, drain in order
    cycle(1, 1, 8'h11, 0, 0);
    cycle(1, 1, 8'h22, 0, 0);
    check("bp_count2", {30'd0, pb_if.count}, 32'd2);
    check("bp_head11", {24'd0, pb_if.dout}, 32'h11);
    cycle(1, 1, 8'h33, 0, 0);
    cycle(1, 0, 8'h00, 1, 0);
    check("bp_head22", {24'd0, pb_if.dout}, 32'h22);
    cycle(1, 0, 8'h00, 1, 0);
    check("bp_count0", {30'd0, pb_if.count}, 32'd0);

    // simultaneous push and pop in ONE
    cycle(1, 1, 8'h40, 0, 0);
    cycle(1, 1, 8'h41, 1, 0);
    check("pp_dout41", {24'd0, pb_if.dout}, 32'h41);
    cycle(1, 0, 8'h00, 1, 0);

    // reset while FULL
    cycle(1, 1, 8'h55, 0, 0);
    cycle(1, 1, 8'h66, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    check("rf_dout_rstv", {24'd0, pb_if.dout}, 32'hA5);
    cycle(1, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h00, 1, 0);

`ifdef NCPU_PIPEBUF_FLUSH_EN
    // flush in FULL with pop and a concurrent offer of 77
    cycle(1, 1, 8'h55, 0, 0);
    cycle(1, 1, 8'h66, 0, 0);
    cycle(1, 1, 8'h77, 1, 1);
    check("fl_count0", {30'd0, pb_if.count}, 32'd0);
    cycle(1, 0, 8'h00, 1, 0);
    check("fl_no77", {31'd0, pb_if.dout == 8'h77}, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit rn, iv, ordy, fl;
      logic [DW-1:0] d;
      rn   = ($urandom_range(0, 49) != 0);
      iv   = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      d    = DW'($urandom);
`ifdef NCPU_PIPEBUF_FLUSH_EN
      fl   = ($urandom_range(0, 15) == 0);
`else
      fl   = 1'b0;
`endif
      cycle(rn, iv, d, ordy, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
